// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and helpers for the PWM peripheral.
//   PWM_BITS        - counter / duty width (fixed at 8)
//   NUM_CHANNELS    - number of driven outputs
//   DEFAULT_CLK_DIV - system clocks per PWM counter step
//   DUTY_FULL       - duty code that means "always high"
package pwm_pkg;

   localparam int PWM_BITS        = 8;
   localparam int NUM_CHANNELS    = 16;
   localparam int DEFAULT_CLK_DIV = 13;

   typedef logic [PWM_BITS-1:0]     pwm_t;
   typedef logic [NUM_CHANNELS-1:0] chan_t;

   localparam pwm_t DUTY_FULL = 8'hFF;
   localparam pwm_t CNT_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,
      CH_HIGH = 2'd1,
      CH_PWM  = 2'd2
   } chan_mode_e;

   // Output enable dominates: the PWM select only matters for enabled channels.
   function automatic chan_mode_e chan_mode(logic en_out, logic en_pwm);
      if (!en_out) return CH_OFF;
      return en_pwm ? CH_PWM : CH_HIGH;
   endfunction

   // Full-scale duty is special-cased so 0xFF gives a true 100% with no
   // low cycle when the counter sits at 255.
   function automatic logic pwm_compare(pwm_t cnt, pwm_t duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus free-running 8-bit PWM period counter.
//   clk, rst_n      - system clock, async active-low reset
//   pwm_counter_o   - current PWM counter value
//   tick_o          - high on the last prescaler cycle of each counter step
//   period_end_o    - high on the last system clock of each PWM period
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output pwm_t pwm_counter_o,
   output logic tick_o,
   output logic period_end_o
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   pwm_t          cnt_q, cnt_d;

   // With CLK_DIV=1 PRE_LAST is 0, so tick is permanently high.
   assign tick_o       = (pre_q == PRE_LAST);
   assign period_end_o = tick_o && (cnt_q == CNT_MAX);

   always_comb begin
      pre_d = tick_o ? '0 : pre_q + 1'b1;
      // Counter wraps 255 -> 0 naturally; there is no hold state.
      cnt_d = tick_o ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign pwm_counter_o = cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel output block fed by SPI configuration registers.
// Each channel is off, static high, or follows one shared PWM waveform.
//   clk, rst_n          - system clock, async active-low reset
//   en_reg_out_*        - per-channel output enable
//   en_reg_pwm_*        - per-channel PWM mode select
//   pwm_duty_cycle      - requested duty, applied at the next period boundary
//   out                 - registered channel outputs
//   period_start        - registered one-clock pulse at the start of each period
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [15:0] out,
   output logic       period_start
);

   pwm_t pwm_counter;
   logic tick, period_end;

   pwm_timebase #(
      .CLK_DIV(CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_counter_o(pwm_counter),
      .tick_o       (tick),
      .period_end_o (period_end)
   );

   // tick is only needed inside the timebase; kept visible for debug.
   logic unused_tick;
   assign unused_tick = tick;

   pwm_t  duty_shadow_q, duty_shadow_d;
   chan_t out_q, out_d;
   logic  period_start_q, period_start_d;
   chan_t en_out, en_pwm;
   logic  pwm_level;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // Duty is sampled only on the last clock of a period so a running pulse
   // is never shortened or extended by a mid-period write.
   assign duty_shadow_d  = period_end ? pwm_duty_cycle : duty_shadow_q;
   assign period_start_d = period_end;
   assign pwm_level      = pwm_compare(pwm_counter, duty_shadow_q);

   // Enables act immediately; only the duty value is period-aligned.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         unique case (chan_mode(en_out[i], en_pwm[i]))
            CH_OFF:  out_d[i] = 1'b0;
            CH_HIGH: out_d[i] = 1'b1;
            CH_PWM:  out_d[i] = pwm_level;
            default: out_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_shadow_q  <= '0;
         out_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         duty_shadow_q  <= duty_shadow_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scenario tasks with inline checks against a
// phase-based reference model of the PWM peripheral (CLK_DIV = 13).
module tb_pwm_peripheral;

   localparam int CLK_DIV = 13;
   localparam int PERIOD  = 256 * CLK_DIV;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00;
   logic [7:0]  duty  = 8'h00;
   logic [15:0] out;
   logic        period_start;

   int checks = 0;
   int errors = 0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_reg_out_7_0 (eo_lo),
      .en_reg_out_15_8(eo_hi),
      .en_reg_pwm_7_0 (ep_lo),
      .en_reg_pwm_15_8(ep_hi),
      .pwm_duty_cycle (duty),
      .out            (out),
      .period_start   (period_start)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Time is tracked as clocks since reset release; the waveform is high for
   // the first hi_time(duty) clocks of each PERIOD-long period.
   int unsigned m_n     = 0;
   logic [7:0]  m_duty  = 8'h00;
   logic [15:0] exp_out = 16'h0000;
   logic        exp_ps  = 1'b0;

   function automatic int hi_time(logic [7:0] d);
      return (d == 8'hFF) ? PERIOD : int'(d) * CLK_DIV;
   endfunction

   function automatic logic [15:0] ref_out(int unsigned n, logic [7:0] d,
                                           logic [15:0] eo, logic [15:0] ep);
      logic lvl;
      lvl = ((n % PERIOD) < hi_time(d));
      return eo & (~ep | {16{lvl}});
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n     <= 0;
         m_duty  <= 8'h00;
         exp_out <= 16'h0000;
         exp_ps  <= 1'b0;
      end else begin
         exp_out <= ref_out(m_n, m_duty, {eo_hi, eo_lo}, {ep_hi, ep_lo});
         exp_ps  <= ((m_n % PERIOD) == PERIOD - 1);
         if ((m_n % PERIOD) == PERIOD - 1) m_duty <= duty;
         m_n <= m_n + 1;
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one period starting just after a period_start sample; sample j
   // reflects period phase j-1. Collects statistics for the caller to judge.
   task automatic window(input int chg_at, input logic [7:0] chg_val, input int exp_hi,
                         output int hi, output int shape_err, output int mism,
                         output logic ps_end);
      hi = 0; shape_err = 0; mism = 0;
      for (int j = 1; j <= PERIOD; j++) begin
         @(negedge clk);
         if (out !== exp_out || period_start !== exp_ps) mism++;
         if (out[0] !== (j <= exp_hi)) shape_err++;
         if (out[0] === 1'b1) hi++;
         if (j == chg_at) duty = chg_val;
      end
      ps_end = period_start;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", period_start); end
      rst_n = 1'b1;
   endtask

   task automatic test_disabled();
      int first, second;
      first = 0; second = 0;
      {eo_hi, eo_lo} = 16'h0000; {ep_hi, ep_lo} = 16'h0000; duty = 8'h80;
      for (int k = 1; k <= 2 * PERIOD; k++) begin
         @(negedge clk);
         checks++;
         if (out !== 16'h0000) begin errors++; $display("FAIL disabled_out k=%0d got %h want 0000", k, out); end
         checks++;
         if (period_start !== exp_ps) begin errors++; $display("FAIL disabled_ps k=%0d got %b want %b", k, period_start, exp_ps); end
         if (period_start === 1'b1) begin
            if (first == 0) first = k; else second = k;
         end
      end
      checks++;
      if (first != PERIOD) begin errors++; $display("FAIL first_period_start got %0d want %0d", first, PERIOD); end
      checks++;
      if (second - first != PERIOD) begin errors++; $display("FAIL period_spacing got %0d want %0d", second - first, PERIOD); end
   endtask

   task automatic test_static();
      logic [15:0] v;
      {eo_hi, eo_lo} = 16'hFFFF; {ep_hi, ep_lo} = 16'h0000;
      @(negedge clk);
      checks++;
      if (out !== 16'hFFFF) begin errors++; $display("FAIL static_all got %h want ffff", out); end
      for (int i = 0; i < 40; i++) begin
         v = 16'($urandom);
         {eo_hi, eo_lo} = v;
         @(negedge clk);
         checks++;
         if (out !== v) begin errors++; $display("FAIL static_rand got %h want %h", out, v); end
      end
   endtask

   task automatic test_pwm50();
      int hi, se, mm; logic pe; bit found;
      do_reset();
      {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0001; duty = 8'h00;
      found = 0;
      for (int k = 1; k <= PERIOD + 4; k++) begin
         @(negedge clk);
         if (k == 100) duty = 8'h80;
         checks++;
         if (out !== 16'h0000) begin errors++; $display("FAIL pwm50_first_period k=%0d got %h want 0000", k, out); end
         if (period_start === 1'b1) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL pwm50_wait_ps got none want pulse"); end
      for (int w = 0; w < 2; w++) begin
         window(0, 8'h80, 1664, hi, se, mm, pe);
         checks++;
         if (hi != 1664) begin errors++; $display("FAIL pwm50_high got %0d want 1664", hi); end
         checks++;
         if (se != 0) begin errors++; $display("FAIL pwm50_shape got %0d bad samples want 0", se); end
         checks++;
         if (mm != 0) begin errors++; $display("FAIL pwm50_model got %0d mismatches want 0", mm); end
         checks++;
         if (pe !== 1'b1) begin errors++; $display("FAIL pwm50_ps_end got %b want 1", pe); end
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] seq [5] = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h40};
      int         want[5] = '{1664, 0, 3328, 3328, 13};
      int hi, se, mm; logic pe;
      for (int i = 0; i < 5; i++) begin
         duty = seq[i];
         window(0, seq[i], want[i], hi, se, mm, pe);
         checks++;
         if (hi != want[i]) begin errors++; $display("FAIL boundary_high[%0d] got %0d want %0d", i, hi, want[i]); end
         checks++;
         if (se != 0) begin errors++; $display("FAIL boundary_shape[%0d] got %0d bad samples want 0", i, se); end
         checks++;
         if (mm != 0 || pe !== 1'b1) begin errors++; $display("FAIL boundary_model[%0d] got mism=%0d ps=%b want 0/1", i, mm, pe); end
      end
   endtask

   task automatic test_midchange();
      int want[2] = '{832, 2496};
      int hi, se, mm; logic pe;
      for (int w = 0; w < 2; w++) begin
         // Write 0xC0 when the counter is at 0x80 in the first window.
         window((w == 0) ? 128 * CLK_DIV : 0, 8'hC0, want[w], hi, se, mm, pe);
         checks++;
         if (hi != want[w]) begin errors++; $display("FAIL midchange_high[%0d] got %0d want %0d", w, hi, want[w]); end
         checks++;
         if (se != 0) begin errors++; $display("FAIL midchange_shape[%0d] got %0d bad samples want 0", w, se); end
         checks++;
         if (mm != 0 || pe !== 1'b1) begin errors++; $display("FAIL midchange_model[%0d] got mism=%0d ps=%b want 0/1", w, mm, pe); end
      end
   endtask

   task automatic test_reset_mid();
      int hi, k_ps;
      {eo_hi, eo_lo} = 16'h0001; {ep_hi, ep_lo} = 16'h0000; duty = 8'hFF;
      repeat (1000) @(negedge clk);
      checks++;
      if (out !== 16'h0001) begin errors++; $display("FAIL rstmid_pre got %h want 0001", out); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL rstmid_async_out got %h want 0000", out); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("FAIL rstmid_async_ps got %b want 0", period_start); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      {ep_hi, ep_lo} = 16'h0001;
      hi = 0; k_ps = 0;
      for (int k = 1; k <= PERIOD + 4; k++) begin
         @(negedge clk);
         checks++;
         if (out !== exp_out || period_start !== exp_ps) begin
            errors++; $display("FAIL rstmid_model k=%0d got %h/%b want %h/%b", k, out, period_start, exp_out, exp_ps);
         end
         if (out[0] === 1'b1) hi++;
         if (period_start === 1'b1) begin k_ps = k; break; end
      end
      checks++;
      if (k_ps != PERIOD) begin errors++; $display("FAIL rstmid_first_ps got %0d want %0d", k_ps, PERIOD); end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL rstmid_first_period_high got %0d want 0", hi); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 2 * PERIOD; k++) begin
         if ($urandom_range(15) == 0) begin
            {eo_hi, eo_lo} = 16'($urandom);
            {ep_hi, ep_lo} = 16'($urandom);
         end
         // Mid-period writes now and then, plus one on every last clock of a
         // period so the coincident-capture case is exercised.
         if ($urandom_range(199) == 0 || (m_n % PERIOD) == PERIOD - 1)
            duty = 8'($urandom);
         @(negedge clk);
         checks++;
         if (out !== exp_out || period_start !== exp_ps) begin
            errors++; $display("FAIL random k=%0d got %h/%b want %h/%b", k, out, period_start, exp_out, exp_ps);
         end
      end
   endtask

   initial begin
      test_reset();
      test_disabled();
      test_static();
      test_pwm50();
      test_boundaries();
      test_midchange();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
